// File: rtl/xintf_bus_arbiter_pkg.sv
// Shared types and constants for the XINTF bus arbiter.
//   state_e     : bus-cycle sequencer states
//   zone_e      : decoded chip-select zone of a request
//   xfer_t      : fields of the winning request, captured at grant
//   zone_decode : maps addr[31:24] onto a zone using the configured tags
package xintf_bus_arbiter_pkg;

  localparam int NUM_REQ = 2;
  localparam int CNT_W   = 4;   // phase counter, covers the 1..15 cycle range
  localparam int TMO_W   = 8;   // wait-state counter

  localparam logic [7:0] ZONE6_TAG_DEF = 8'h01;
  localparam logic [7:0] ZONE7_TAG_DEF = 8'h02;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_WAIT,
    ST_HOLD,
    ST_DONE
  } state_e;

  typedef enum logic [1:0] {
    ZN_NONE,
    ZN_6,
    ZN_7
  } zone_e;

  typedef struct packed {
    logic        id;
    logic        we;
    zone_e       zone;
    logic [15:0] xa;
    logic [15:0] wdata;
  } xfer_t;

  // Zone 6 takes priority should both tags be configured identically, so
  // at most one chip select can ever be selected.
  function automatic zone_e zone_decode(input logic [7:0] tag,
                                        input logic [7:0] z6_tag,
                                        input logic [7:0] z7_tag);
    zone_e z;
    z = ZN_NONE;
    if (tag == z6_tag)      z = ZN_6;
    else if (tag == z7_tag) z = ZN_7;
    return z;
  endfunction

endpackage

// File: rtl/xintf_bus_arbiter_if.sv
// Requester-side handshake bundle of the XINTF bus arbiter.
//   req   : per-requester transfer request (level, held until done)
//   we    : per-requester 1=write, 0=read
//   addr  : {addr1[31:0], addr0[31:0]}
//   wdata : {wdata1[15:0], wdata0[15:0]}
//   rdata : read data of the last completed read (shared)
//   done  : one-cycle completion pulse per requester
//   err   : one-cycle error pulse, coincident with done
//   busy  : sequencer not idle
// slave modport is taken by the arbiter, master by the requesters.
interface xintf_bus_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  we;
  logic [63:0] addr;
  logic [31:0] wdata;
  logic [15:0] rdata;
  logic [1:0]  done;
  logic [1:0]  err;
  logic        busy;

  modport slave (
    input  req, we, addr, wdata,
    output rdata, done, err, busy
  );

  modport master (
    output req, we, addr, wdata,
    input  rdata, done, err, busy
  );
endinterface

// File: rtl/xintf_bus_arbiter_rr_arb.sv
// Two-way round-robin arbiter.
//   clk, reset_n : clock, async active-low reset
//   req          : request vector
//   accept       : the current grant is being taken (sequencer idle)
//   grant        : one-hot winner, zero when nobody requests
// The last-grant pointer resets to requester 1 so requester 0 wins the
// first contested round.
module xintf_bus_arbiter_rr_arb
  import xintf_bus_arbiter_pkg::*;
(
  input  logic               clk,
  input  logic               reset_n,
  input  logic [NUM_REQ-1:0] req,
  input  logic               accept,
  output logic [NUM_REQ-1:0] grant
);

  logic last_q;

  always_comb begin
    grant = '0;
    case (req)
      2'b01:   grant = 2'b01;
      2'b10:   grant = 2'b10;
      2'b11:   grant = last_q ? 2'b01 : 2'b10;
      default: grant = '0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)                last_q <= 1'b1;
    else if (accept && (|grant)) last_q <= grant[1];
  end

endmodule

// File: rtl/xintf_bus_arbiter.sv
// XINTF bus arbiter: shares one XINTF master port between two requesters,
// grants round-robin and runs each transfer as SETUP/STROBE/(WAIT)/HOLD.
//   clk, reset_n        : clock, async active-low reset
//   bus                 : requester handshake (xintf_bus_arbiter_if.slave)
//   xa                  : XINTF address, latched addr[15:0]
//   xd                  : XINTF data, driven only during write cycles
//   xwen, xrdn          : write / read strobes, active-low
//   zone_6_n, zone_7_n  : chip selects, active-low
//   xready              : slave ready, active-high
// All pin outputs are flops updated together with the sequencer state.
module xintf_bus_arbiter
  import xintf_bus_arbiter_pkg::*;
#(
  parameter int         SETUP_CYC  = 1,
  parameter int         STROBE_CYC = 2,
  parameter int         HOLD_CYC   = 1,
  parameter bit         USE_READY  = 1'b1,
  parameter int         TIMEOUT    = 255,
  parameter logic [7:0] ZONE6_TAG  = ZONE6_TAG_DEF,
  parameter logic [7:0] ZONE7_TAG  = ZONE7_TAG_DEF
) (
  input  logic                clk,
  input  logic                reset_n,
  xintf_bus_arbiter_if.slave  bus,
  output logic [15:0]         xa,
  inout  wire  [15:0]         xd,
  output logic                xwen,
  output logic                xrdn,
  output logic                zone_6_n,
  output logic                zone_7_n,
  input  logic                xready
);

  // Phase counters count down to zero, so each reload is length-1.
  localparam logic [CNT_W-1:0] SETUP_LD  = CNT_W'(SETUP_CYC - 1);
  localparam logic [CNT_W-1:0] STROBE_LD = CNT_W'(STROBE_CYC - 1);
  localparam logic [CNT_W-1:0] HOLD_LD   = CNT_W'(HOLD_CYC - 1);
  localparam logic [TMO_W-1:0] TMO_LAST  = TMO_W'((TIMEOUT > 0) ? TIMEOUT - 1 : 0);

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [TMO_W-1:0] wcnt_q;
  logic             cur_we_q;
  logic             cur_id_q;
  logic [15:0]      xd_out_q;
  logic             xd_oe_q;
  logic [15:0]      rdata_q;
  logic [1:0]       done_q;
  logic [1:0]       err_q;

  logic [1:0]       grant;
  logic [31:0]      sel_addr;
  xfer_t            win;
  logic [1:0]       cur_oh;
  logic             ready_ok;
  logic             unused_addr_mid;

  xintf_bus_arbiter_rr_arb u_arb (
    .clk     (clk),
    .reset_n (reset_n),
    .req     (bus.req),
    .accept  (state_q == ST_IDLE),
    .grant   (grant)
  );

  // Candidate transfer from whichever requester the arbiter picks.
  always_comb begin
    sel_addr  = grant[1] ? bus.addr[63:32] : bus.addr[31:0];
    win.id    = grant[1];
    win.we    = grant[1] ? bus.we[1] : bus.we[0];
    win.zone  = zone_decode(sel_addr[31:24], ZONE6_TAG, ZONE7_TAG);
    win.xa    = sel_addr[15:0];
    win.wdata = grant[1] ? bus.wdata[31:16] : bus.wdata[15:0];
  end

  assign unused_addr_mid = ^sel_addr[23:16];

  assign cur_oh   = cur_id_q ? 2'b10 : 2'b01;
  assign ready_ok = !USE_READY || xready;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      wcnt_q   <= '0;
      cur_we_q <= 1'b0;
      cur_id_q <= 1'b0;
      xa       <= '0;
      xd_out_q <= '0;
      xd_oe_q  <= 1'b0;
      xwen     <= 1'b1;
      xrdn     <= 1'b1;
      zone_6_n <= 1'b1;
      zone_7_n <= 1'b1;
      rdata_q  <= '0;
      done_q   <= '0;
      err_q    <= '0;
    end else begin
      done_q <= '0;
      err_q  <= '0;
      case (state_q)
        ST_IDLE: begin
          if (|grant) begin
            cur_we_q <= win.we;
            cur_id_q <= win.id;
            if (win.zone == ZN_NONE) begin
              // Unmapped tag: report straight away, never touch the pins.
              state_q <= ST_DONE;
              done_q  <= grant;
              err_q   <= grant;
            end else begin
              state_q  <= ST_SETUP;
              cnt_q    <= SETUP_LD;
              xa       <= win.xa;
              zone_6_n <= (win.zone != ZN_6);
              zone_7_n <= (win.zone != ZN_7);
              xd_out_q <= win.wdata;
              xd_oe_q  <= win.we;
            end
          end
        end

        ST_SETUP: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q <= ST_STROBE;
            cnt_q   <= STROBE_LD;
            xwen    <= ~cur_we_q;
            xrdn    <= cur_we_q;
          end
        end

        ST_STROBE: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else if (ready_ok) begin
            // This was the last low-strobe cycle: sample read data now.
            if (!cur_we_q) rdata_q <= xd;
            xwen <= 1'b1;
            xrdn <= 1'b1;
            if (HOLD_CYC == 0) begin
              state_q  <= ST_DONE;
              zone_6_n <= 1'b1;
              zone_7_n <= 1'b1;
              xd_oe_q  <= 1'b0;
              done_q   <= cur_oh;
            end else begin
              state_q <= ST_HOLD;
              cnt_q   <= HOLD_LD;
            end
          end else begin
            state_q <= ST_WAIT;
            wcnt_q  <= '0;
          end
        end

        ST_WAIT: begin
          if (xready) begin
            if (!cur_we_q) rdata_q <= xd;
            xwen <= 1'b1;
            xrdn <= 1'b1;
            if (HOLD_CYC == 0) begin
              state_q  <= ST_DONE;
              zone_6_n <= 1'b1;
              zone_7_n <= 1'b1;
              xd_oe_q  <= 1'b0;
              done_q   <= cur_oh;
            end else begin
              state_q <= ST_HOLD;
              cnt_q   <= HOLD_LD;
            end
          end else if (wcnt_q == TMO_LAST) begin
            // Slave never answered: drop everything, rdata left untouched.
            state_q  <= ST_DONE;
            xwen     <= 1'b1;
            xrdn     <= 1'b1;
            zone_6_n <= 1'b1;
            zone_7_n <= 1'b1;
            xd_oe_q  <= 1'b0;
            done_q   <= cur_oh;
            err_q    <= cur_oh;
          end else begin
            wcnt_q <= wcnt_q + 1'b1;
          end
        end

        ST_HOLD: begin
          if (cnt_q != '0) begin
            cnt_q <= cnt_q - 1'b1;
          end else begin
            state_q  <= ST_DONE;
            zone_6_n <= 1'b1;
            zone_7_n <= 1'b1;
            xd_oe_q  <= 1'b0;
            done_q   <= cur_oh;
          end
        end

        ST_DONE: state_q <= ST_IDLE;

        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign xd        = xd_oe_q ? xd_out_q : 16'hzzzz;
  assign bus.rdata = rdata_q;
  assign bus.done  = done_q;
  assign bus.err   = err_q;
  assign bus.busy  = (state_q != ST_IDLE);

endmodule

// File: tb/tb_xintf_bus_arbiter.sv
module tb_xintf_bus_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] xa;
  wire  [15:0] xd;
  logic        xwen, xrdn, zone_6_n, zone_7_n;
  logic        xready;
  logic [15:0] slave_val;
  logic        tb_force;

  int errors = 0;
  int checks = 0;

  xintf_bus_arbiter_if bus();

  xintf_bus_arbiter dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .bus      (bus),
    .xa       (xa),
    .xd       (xd),
    .xwen     (xwen),
    .xrdn     (xrdn),
    .zone_6_n (zone_6_n),
    .zone_7_n (zone_7_n),
    .xready   (xready)
  );

  // Slave model: returns slave_val whenever a read strobe is active.
  assign xd = (!xrdn || tb_force) ? slave_val : 16'hzzzz;

  always #5 clk = ~clk;

  typedef struct {
    logic [1:0]  done;
    logic [1:0]  err;
    logic        chk_rd;
    logic [15:0] rdata;
    logic        chk_xa;
    logic [15:0] xa;
    logic        chk_xd;
    logic [15:0] xd;
    int          z6, z7, wen, rdn, lat;
  } exp_t;

  exp_t exp_q[$];
  exp_t m_e;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", nm, act, exp);
    end
  endtask

  task automatic push(input logic [1:0] d, input logic [1:0] e,
                      input logic chk_rd, input logic [15:0] rd,
                      input logic chk_xa, input logic [15:0] a,
                      input logic chk_xd, input logic [15:0] wd,
                      input int z6, input int z7, input int wen, input int rdn,
                      input int lat);
    exp_t x;
    x.done = d; x.err = e; x.chk_rd = chk_rd; x.rdata = rd;
    x.chk_xa = chk_xa; x.xa = a; x.chk_xd = chk_xd; x.xd = wd;
    x.z6 = z6; x.z7 = z7; x.wen = wen; x.rdn = rdn; x.lat = lat;
    exp_q.push_back(x);
  endtask

  // Monitor: accumulates pin activity per transfer, scores it on done.
  int a_z6, a_z7, a_wen, a_rdn, a_lat, a_both, xn;
  logic [15:0] a_xa, a_xd;

  always @(negedge clk) begin
    if (!reset_n) begin
      a_z6 = 0; a_z7 = 0; a_wen = 0; a_rdn = 0; a_lat = 0; a_both = 0;
      a_xa = '0; a_xd = '0;
    end else begin
      if (bus.busy) a_lat++;
      if (!zone_6_n) a_z6++;
      if (!zone_7_n) a_z7++;
      if (!zone_6_n && !zone_7_n) a_both++;
      if (!zone_6_n || !zone_7_n) a_xa = xa;
      if (!xwen) begin a_wen++; a_xd = xd; end
      if (!xrdn) a_rdn++;
      if (bus.err != 2'b00 && bus.done == 2'b00) begin
        checks++; errors++;
        $display("FAIL err_without_done: got err=%b done=%b", bus.err, bus.done);
      end
      if (bus.done != 2'b00) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("FAIL unexpected_done: got done=%b expected none", bus.done);
        end else begin
          m_e = exp_q.pop_front();
          chk($sformatf("x%0d_done", xn), int'(bus.done), int'(m_e.done));
          chk($sformatf("x%0d_err", xn), int'(bus.err), int'(m_e.err));
          chk($sformatf("x%0d_zone6_cycles", xn), a_z6, m_e.z6);
          chk($sformatf("x%0d_zone7_cycles", xn), a_z7, m_e.z7);
          chk($sformatf("x%0d_xwen_cycles", xn), a_wen, m_e.wen);
          chk($sformatf("x%0d_xrdn_cycles", xn), a_rdn, m_e.rdn);
          chk($sformatf("x%0d_latency", xn), a_lat, m_e.lat);
          chk($sformatf("x%0d_both_zones", xn), a_both, 0);
          if (m_e.chk_rd) chk($sformatf("x%0d_rdata", xn), int'(bus.rdata), int'(m_e.rdata));
          if (m_e.chk_xa) chk($sformatf("x%0d_xa", xn), int'(a_xa), int'(m_e.xa));
          if (m_e.chk_xd) chk($sformatf("x%0d_xd", xn), int'(a_xd), int'(m_e.xd));
        end
        xn++;
        a_z6 = 0; a_z7 = 0; a_wen = 0; a_rdn = 0; a_lat = 0; a_both = 0;
      end
    end
  end

  task automatic set_req(input int idx, input logic w, input logic [31:0] a,
                         input logic [15:0] d);
    bus.we[idx]          = w;
    bus.addr[idx*32 +: 32] = a;
    bus.wdata[idx*16 +: 16] = d;
    bus.req[idx]         = 1'b1;
  endtask

  // Hold requests until n done pulses, then drop them (still inside DONE).
  task automatic run_until(input int n, input int budget, input string nm);
    int got;
    int cyc;
    got = 0; cyc = 0;
    while (got < n && cyc < budget) begin
      @(negedge clk);
      cyc++;
      if (bus.done != 2'b00) got++;
    end
    bus.req = 2'b00;
    checks++;
    if (got < n) begin
      errors++;
      $display("FAIL %s_timeout: got %0d dones expected %0d", nm, got, n);
    end
  endtask

  task automatic ready_after_low(input int lowcyc, input int budget);
    int n;
    n = 0;
    for (int c = 0; c < budget && n < lowcyc; c++) begin
      @(negedge clk);
      if (!xrdn) n++;
    end
    xready = 1'b1;
  endtask

  task automatic wait_strobe(input int budget);
    int c;
    c = 0;
    while (xwen && c < budget) begin
      @(negedge clk);
      c++;
    end
    checks++;
    if (xwen) begin
      errors++;
      $display("FAIL t6_strobe_timeout: got xwen=%b expected 0", xwen);
    end
  endtask

  initial begin
    bus.req = '0; bus.we = '0; bus.addr = '0; bus.wdata = '0;
    xready = 1'b1; slave_val = '0; tb_force = 1'b0; xn = 0;

    repeat (2) @(negedge clk);
    #1;
    chk("rst_xwen", int'(xwen), 1);
    chk("rst_xrdn", int'(xrdn), 1);
    chk("rst_zone6", int'(zone_6_n), 1);
    chk("rst_zone7", int'(zone_7_n), 1);
    chk("rst_xa", int'(xa), 0);
    chk("rst_rdata", int'(bus.rdata), 0);
    chk("rst_done", int'(bus.done), 0);
    chk("rst_err", int'(bus.err), 0);
    chk("rst_busy", int'(bus.busy), 0);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);

    // 1: write to zone 6
    push(2'b01, 2'b00, 0, 16'h0, 1, 16'h1000, 1, 16'h0AA0, 4, 0, 2, 0, 5);
    set_req(0, 1'b1, 32'h01001000, 16'h0AA0);
    run_until(1, 50, "t1");
    @(negedge clk);

    // 2: read from zone 7
    slave_val = 16'hBEEF;
    push(2'b01, 2'b00, 1, 16'hBEEF, 1, 16'h2000, 0, 16'h0, 0, 4, 0, 2, 5);
    set_req(0, 1'b0, 32'h02002000, 16'h0);
    run_until(1, 50, "t2");
    @(negedge clk);

    // 5: bad zone from requester 1 (also leaves last-grant on 1)
    push(2'b10, 2'b10, 1, 16'hBEEF, 0, 16'h0, 0, 16'h0, 0, 0, 0, 0, 1);
    set_req(1, 1'b1, 32'h05000000, 16'hDEAD);
    run_until(1, 50, "t5");
    @(negedge clk);

    // 3: both requesting, grants alternate 0,1,0,1
    slave_val = 16'h2222;
    for (int i = 0; i < 2; i++) begin
      push(2'b01, 2'b00, 0, 16'h0, 1, 16'h0010, 1, 16'h1111, 4, 0, 2, 0, 5);
      push(2'b10, 2'b00, 1, 16'h2222, 1, 16'h0020, 0, 16'h0, 0, 4, 0, 2, 5);
    end
    set_req(0, 1'b1, 32'h01000010, 16'h1111);
    set_req(1, 1'b0, 32'h02000020, 16'h0);
    run_until(4, 100, "t3");
    @(negedge clk);

    // 4a: five wait states, strobe low 7 cycles in total
    xready = 1'b0;
    slave_val = 16'h1234;
    push(2'b01, 2'b00, 1, 16'h1234, 1, 16'h3000, 0, 16'h0, 0, 9, 0, 7, 10);
    set_req(0, 1'b0, 32'h02003000, 16'h0);
    fork
      run_until(1, 100, "t4a");
      ready_after_low(7, 100);
    join
    @(negedge clk);

    // 4b: xready stuck low -> timeout, rdata keeps the previous read
    xready = 1'b0;
    slave_val = 16'h9999;
    push(2'b01, 2'b01, 1, 16'h1234, 1, 16'h4000, 0, 16'h0, 258, 0, 0, 257, 259);
    set_req(0, 1'b0, 32'h01004000, 16'h0);
    run_until(1, 400, "t4b");
    xready = 1'b1;
    @(negedge clk);

    // 6: reset during the strobe
    set_req(0, 1'b1, 32'h01005000, 16'h0F0F);
    wait_strobe(20);
    reset_n = 1'b0;
    #1;
    chk("t6_xwen", int'(xwen), 1);
    chk("t6_xrdn", int'(xrdn), 1);
    chk("t6_zone6", int'(zone_6_n), 1);
    chk("t6_zone7", int'(zone_7_n), 1);
    chk("t6_xa", int'(xa), 0);
    chk("t6_busy", int'(bus.busy), 0);
    chk("t6_rdata", int'(bus.rdata), 0);
    bus.req = 2'b00;
    slave_val = 16'h5A5A;
    tb_force = 1'b1;
    #1;
    chk("t6_xd_released", int'(xd), 16'h5A5A);
    tb_force = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    push(2'b01, 2'b00, 0, 16'h0, 1, 16'h6000, 1, 16'h3333, 4, 0, 2, 0, 5);
    push(2'b10, 2'b00, 0, 16'h0, 1, 16'h7000, 1, 16'h4444, 0, 4, 2, 0, 5);
    set_req(0, 1'b1, 32'h01006000, 16'h3333);
    set_req(1, 1'b1, 32'h02007000, 16'h4444);
    run_until(2, 100, "t6_after");
    repeat (3) @(negedge clk);

    chk("leftover_expected", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    errors++;
    checks++;
    $display("FAIL watchdog: simulation did not complete in time");
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
